// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR MAC sequencer.
// Contents:
//   - default parameter values (TAPS, DW, CW, AW)
//   - DEFAULT_COEFF: reset image of the coefficient store. Entries at
//     index 10 and above are zero.
//   - state_t: sequencer states
//   - accumulator guard bits and the default accumulator width
package fir_pkg;

  localparam int TAPS_DEF = 10;
  localparam int DW_DEF   = 32;
  localparam int CW_DEF   = 32;
  localparam int AW_DEF   = 4;
  localparam int MAX_TAPS = 16;

  // Four guard bits cover the growth from summing up to 16 products.
  localparam int ACC_GUARD = 4;
  localparam int ACC_W_DEF = DW_DEF + CW_DEF + ACC_GUARD;

  localparam int DEFAULT_COEFF [MAX_TAPS] = '{
    -3, 4, 6, -2, -5, 3, 7, 2, -1, 4, 0, 0, 0, 0, 0, 0
  };

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

endpackage

// File: rtl/fir_coeff_regfile.sv
// Coefficient store for the FIR sequencer.
// It holds TAPS registers of CW bits. The read port is combinational and is
// indexed by the current tap. The write port is gated.
// Ports:
//   clk, reset  clock and synchronous active-high reset. Reset loads the
//               package default coefficients.
//   we          write strobe
//   enable      write enable from the sequencer (high only in IDLE)
//   addr, data  write index and value. Writes to an index >= TAPS are dropped.
//   raddr       read index (tap counter)
//   rdata       coefficient at raddr
module fir_coeff_regfile
  import fir_pkg::*;
#(
  parameter int TAPS = TAPS_DEF,
  parameter int CW   = CW_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic                 enable,
  input  logic [AW-1:0]        addr,
  input  logic signed [CW-1:0] data,
  input  logic [AW-1:0]        raddr,
  output logic signed [CW-1:0] rdata
);

  // The limit is one bit wider than addr so that TAPS = 2**AW still compares correctly.
  localparam logic [AW:0] TAPS_LIM = (AW + 1)'(TAPS);

  logic signed [CW-1:0] regs [TAPS];
  logic                 write_ok;

  assign write_ok = we && enable && ({1'b0, addr} < TAPS_LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        regs[i] <= CW'(DEFAULT_COEFF[i]);
      end
    end else if (write_ok) begin
      regs[addr] <= data;
    end
  end

  assign rdata = regs[raddr];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller.
// It owns the tap delay line and the coefficient store. One shared
// multiply-accumulate unit processes one tap per cycle.
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   s_valid/s_ready    upstream sample handshake; s_data is the signed sample
//   m_valid/m_ready    downstream result handshake; m_data is the signed result
//   cfg_we/addr/data   runtime coefficient write. It commits only in IDLE.
//   busy               high whenever the sequencer is not in IDLE
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS = TAPS_DEF,
  parameter int DW   = DW_DEF,
  parameter int CW   = CW_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [DW-1:0] m_data,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic signed [CW-1:0] cfg_data,
  output logic                 busy
);

  localparam int              ACC_W    = DW + CW + ACC_GUARD;
  localparam logic [AW-1:0]   LAST_TAP = AW'(TAPS - 1);

  state_t                     state;
  logic signed [DW-1:0]       delay [TAPS];
  logic [AW-1:0]              tap;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    acc_next;
  logic signed [CW-1:0]       coeff;
  logic signed [DW+CW-1:0]    product;

  fir_coeff_regfile #(
    .TAPS (TAPS),
    .CW   (CW),
    .AW   (AW)
  ) u_coeff (
    .clk    (clk),
    .reset  (reset),
    .we     (cfg_we),
    .enable (state == IDLE),
    .addr   (cfg_addr),
    .data   (cfg_data),
    .raddr  (tap),
    .rdata  (coeff)
  );

  // Shared MAC. The full-width signed product is sign-extended into the guard bits.
  assign product  = delay[tap] * coeff;
  assign acc_next = acc + {{ACC_GUARD{product[DW+CW-1]}}, product};

  assign s_ready = (state == IDLE);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tap     <= '0;
      acc     <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        delay[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            for (int i = TAPS - 1; i > 0; i--) begin
              delay[i] <= delay[i-1];
            end
            delay[0] <= s_data;
            acc      <= '0;
            tap      <= '0;
            state    <= ACC;
          end
        end
        ACC: begin
          acc <= acc_next;
          tap <= tap + 1'b1;
          // The last tap's sum is captured straight into the output register,
          // so m_data is ready when DONE is entered.
          if (tap == LAST_TAP) begin
            m_data  <= acc_next[DW-1:0];
            m_valid <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer.
// Expected results come from a behavioural model of the FIR (its own delay
// line and coefficient copy). They go into a scoreboard queue when a sample
// is accepted and are compared when the result handshakes out. Table vectors
// and explicit constants check the impulse response and the corner cases.
module tb_fir_mac_sequencer;

  localparam int TAPS = 10;

  logic               clk = 1'b0;
  logic               reset;
  logic               s_valid;
  logic               s_ready;
  logic signed [31:0] s_data;
  logic               m_valid;
  logic               m_ready;
  logic signed [31:0] m_data;
  logic               cfg_we;
  logic [3:0]         cfg_addr;
  logic signed [31:0] cfg_data;
  logic               busy;

  always #5 clk = ~clk;

  fir_mac_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .busy     (busy)
  );

  typedef struct {
    logic signed [31:0] sample;
    logic signed [31:0] expected;
  } vec_t;

  localparam int DEF_COEFF [TAPS] = '{-3, 4, 6, -2, -5, 3, 7, 2, -1, 4};

  vec_t               impulse_tbl [11];
  logic signed [31:0] mx [TAPS];
  logic signed [31:0] mcoef [TAPS];
  logic signed [31:0] sb_q [$];
  logic               accepted;
  int                 vectors = 0;
  int                 miscompares = 0;

  function automatic void model_reset();
    for (int i = 0; i < TAPS; i++) begin
      mx[i]    = 0;
      mcoef[i] = DEF_COEFF[i];
    end
  endfunction

  function automatic logic signed [31:0] model_accept(input logic signed [31:0] sample);
    longint sum = 0;
    for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = sample;
    for (int k = 0; k < TAPS; k++) sum += longint'(mx[k]) * longint'(mcoef[k]);
    return 32'(sum);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
    end
  endtask

  // Observe both handshakes just before the edge, then step to 1 time unit after it.
  task automatic tick();
    accepted = 1'b0;
    if (s_valid && s_ready) begin
      sb_q.push_back(model_accept(s_data));
      accepted = 1'b1;
    end
    if (m_valid && m_ready) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL sb_unexpected: got 0x%h, expected no output", m_data);
      end else begin
        checkOutput("scoreboard", m_data, sb_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic signed [31:0] sample);
    int n = 0;
    s_valid = 1'b1;
    s_data  = sample;
    do begin
      tick();
      n++;
    end while (!accepted && n < 40);
    s_valid = 1'b0;
    cfg_we  = 1'b0;
    checkOutput("accept_timeout", 32'(accepted), 32'd1);
  endtask

  task automatic waitValid(input string name);
    int n = 0;
    while (!m_valid && n < 40) begin
      tick();
      n++;
    end
    checkOutput({name, "_valid"}, 32'(m_valid), 32'd1);
  endtask

  task automatic cfgWrite(input logic [3:0] addr, input logic signed [31:0] data, input bit commit);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    tick();
    cfg_we = 1'b0;
    if (commit) mcoef[addr] = data;
  endtask

  task automatic doReset();
    reset   = 1'b1;
    s_valid = 1'b0;
    cfg_we  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
    sb_q.delete();
  endtask

  task automatic runImpulse(input string name);
    for (int i = 0; i < 11; i++) begin
      applyStimulus(impulse_tbl[i].sample);
      waitValid(name);
      checkOutput($sformatf("%s_%0d", name, i), m_data, impulse_tbl[i].expected);
      tick();
    end
  endtask

  initial begin
    int exp_list [11] = '{-3, 4, 6, -2, -5, 3, 7, 2, -1, 4, 0};
    for (int i = 0; i < 11; i++) begin
      impulse_tbl[i].sample   = (i == 0) ? 32'sd1 : 32'sd0;
      impulse_tbl[i].expected = exp_list[i];
    end

    s_valid  = 1'b0;
    s_data   = '0;
    m_ready  = 1'b1;
    cfg_we   = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    model_reset();
    doReset();

    checkOutput("reset_m_valid", 32'(m_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_s_ready", 32'(s_ready), 32'd1);
    checkOutput("reset_m_data", m_data, 32'd0);

    // Impulse response with the default coefficients
    runImpulse("impulse_default");

    // Latency: k counts edges after the accepting edge T.
    applyStimulus(32'sd9);
    for (int k = 0; k <= 11; k++) begin
      checkOutput($sformatf("latency_k%0d", k), {30'b0, s_ready, m_valid},
                  {30'b0, (k == 11), (k == 10)});
      if (k < 11) tick();
    end

    // Backpressure: the result holds while upstream keeps offering the next sample.
    m_ready = 1'b0;
    applyStimulus(32'sd5);
    waitValid("bp");
    s_valid = 1'b1;
    s_data  = 32'sd77;
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp_hold", {30'b0, s_ready, m_valid}, 32'b01);
      checkOutput("bp_data", m_data, sb_q[0]);
      tick();
    end
    m_ready = 1'b1;
    applyStimulus(32'sd77);
    waitValid("bp_next");
    tick();
    checkOutput("bp_queue", 32'(sb_q.size()), 32'd0);

    // Config port
    doReset();
    cfgWrite(4'd0, 32'sd10, 1'b1);
    applyStimulus(32'sd1);
    cfg_we   = 1'b1;
    cfg_addr = 4'd2;
    cfg_data = 32'sd99;
    tick();
    cfg_we = 1'b0;
    waitValid("cfg_addr0");
    checkOutput("cfg_addr0", m_data, 32'sd10);
    tick();
    cfgWrite(4'd12, 32'sd55, 1'b0);
    cfg_we   = 1'b1;
    cfg_addr = 4'd1;
    cfg_data = 32'sd20;
    mcoef[1] = 32'sd20;
    applyStimulus(32'sd0);
    waitValid("cfg_same_cycle");
    checkOutput("cfg_same_cycle", m_data, 32'sd20);
    tick();
    applyStimulus(32'sd0);
    waitValid("cfg_drop_acc");
    checkOutput("cfg_drop_acc", m_data, 32'sd6);
    tick();

    // Reset while the MAC is on tap 5
    applyStimulus(32'sd3);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midreset_m_valid", 32'(m_valid), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_s_ready", 32'(s_ready), 32'd1);
    model_reset();
    sb_q.delete();
    runImpulse("impulse_after_reset");

    // Two's-complement wrap of the output
    for (int i = 0; i < 7; i++) begin
      applyStimulus((i == 0) ? 32'sh7FFFFFFF : 32'sd0);
      waitValid("wrap");
      if (i == 6) checkOutput("wrap", m_data, 32'h7FFFFFF9);
      tick();
    end

    checkOutput("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
